mips_mc_controller: RTL and testbench
=====================================

// Module: mips_mc_controller
// PURPOSE
// - Multicycle MIPS control unit: main FSM plus ALU decoder. Issues the 3-bit alucontrol code and all datapath
//   enables, one instruction phase per clock. Sits between the instruction register (op/funct) and the datapath/ALU.
// - ALU code map (fixed): AND=000 OR=001 ADD=010 SUB=110 MUL=101 SLT=111. Other codes are never issued.
// PARAMETERS
// - ILLEGAL_TRAP  default 0  1: an illegal instruction parks the FSM in HALT until reset; 0: it returns to FETCH.
// PORTS
// - clk         in   1  system clock, all state on rising edge
// - reset       in   1  synchronous, active-high
// - op          in   6  instr[31:26] from instruction register
// - funct       in   6  instr[5:0] from instruction register
// - zero        in   1  ALU zero flag (aluout == 0), same cycle
// - alucontrol  out  3  ALU operation code (map above)
// - alusrca     out  1  0: PC, 1: register A
// - alusrcb     out  2  00: reg B, 01: const 4, 10: sign-ext imm, 11: sign-ext imm << 2
// - pcsrc       out  2  00: ALU result, 01: ALUOut reg, 10: jump target
// - iord        out  1  0: memory address = PC, 1: ALUOut
// - irwrite     out  1  load instruction register
// - memwrite    out  1  data memory write strobe
// - regwrite    out  1  register file write
// - regdst      out  1  0: rt, 1: rd
// - memtoreg    out  1  0: ALUOut, 1: data register
// - pcen        out  1  PC load enable = pcwrite | (branch taken)
// - illegal     out  1  one-cycle pulse on undecodable op/funct
// - state_o     out  4  current state encoding (debug)
// BEHAVIOUR
// - States (state_o): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 RTEX=6 RTWB=7 BEQEX=8 ADDIEX=9 ADDIWB=10
//   JEX=11 HALT=15 (BNEEX=12 with macro). All outputs except pcen are Moore (decoded from state only).
// - FETCH: iord=0 alusrca=0 alusrcb=01 alucontrol=010 pcsrc=00 irwrite=1 pcwrite=1 -> DECODE.
// - DECODE: alusrca=0 alusrcb=11 alucontrol=010 (branch target precompute). Next by op:
//   100011/101011 -> MEMADR; 000000 with legal funct -> RTEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX;
//   anything else -> illegal=1 this cycle, next FETCH (ILLEGAL_TRAP=0) or HALT (ILLEGAL_TRAP=1).
// - MEMADR: alusrca=1 alusrcb=10 alucontrol=010 -> MEMRD (lw) / MEMWR (sw). MEMRD: iord=1 -> MEMWB.
//   MEMWB: regdst=0 memtoreg=1 regwrite=1 -> FETCH. MEMWR: iord=1 memwrite=1 -> FETCH.
// - RTEX: alusrca=1 alusrcb=00 alucontrol from funct: 100000->010 100010->110 100100->000 100101->001
//   101010->111 011000->101 -> RTWB. RTWB: regdst=1 memtoreg=0 regwrite=1 -> FETCH.
// - Legal funct set is exactly the six above; other funct with op=000000 is illegal at DECODE (no RTEX entered).
// - BEQEX: alusrca=1 alusrcb=00 alucontrol=110 pcsrc=01 branch=1; pcen=zero (combinational) -> FETCH.
// - ADDIEX: alusrca=1 alusrcb=10 alucontrol=010 -> ADDIWB: regdst=0 memtoreg=0 regwrite=1 -> FETCH.
// - JEX: pcsrc=10 pcwrite=1 -> FETCH. HALT: all enables 0, stays until reset.
// - Defaults in any state: every enable 0, select fields 0, alucontrol=010.
// - Latency (cycles incl. FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
// - Reset: while reset=1 at a clock edge state <= FETCH; while reset is high irwrite, pcen, memwrite, regwrite,
//   illegal are forced 0 (other outputs show FETCH values). Reset mid-instruction abandons it; no write completes.
// - zero is sampled only in BEQEX/BNEEX; pcen ignores zero in all other states.
// CONFIGURATION
// - MC_BNE_EN defined: op 000101 decodes to BNEEX (as BEQEX but pcen = ~zero), 3 cycles.
// - MC_BNE_EN undefined: op 000101 is illegal (illegal pulse, ILLEGAL_TRAP rules apply); state 12 unreachable.
// TESTING
// - reset held 2 cycles, release, op=100011 -> state_o 0,1,2,3,4,0; regwrite=1 & memtoreg=1 only in MEMWB.
// - op=000000 funct=101010 -> RTEX alucontrol=111, RTWB regdst=1 regwrite=1; funct=011000 -> alucontrol=101.
// - op=000100 zero=1 in BEQEX -> pcen=1 pcsrc=01; repeat zero=0 -> pcen=0; both return to FETCH next cycle.
// - op=111111, ILLEGAL_TRAP=0 -> illegal=1 in DECODE, FETCH next; ILLEGAL_TRAP=1 -> HALT, enables 0 until reset.
// - reset asserted in MEMWR -> memwrite=0 that cycle, state_o=0 next cycle; FETCH re-runs normally.
// - MC_BNE_EN on: op=000101 zero=0 -> pcen=1 in state 12; MC_BNE_EN off: same op -> illegal pulse.

Source files
------------

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: main FSM with registered Moore outputs plus ALU decoder.
// Optional feature: define MC_BNE_EN to decode bne (op 000101) into the BNEEX state.
module mips_mc_controller #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       pcen,
    output logic       illegal,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  RTEX   = 4'd6,  RTWB   = 4'd7,
        BEQEX  = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JEX    = 4'd11,
        BNEEX  = 4'd12, HALT   = 4'd15
    } state_t;

    typedef struct packed {
        logic [2:0] alucontrol;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       pcwrite;
        logic       branch;
        logic       bne;
    } ctrl_t;

    state_t state, state_next;
    ctrl_t  ctrl;
    logic   funct_legal;
    logic   op_legal;
    logic [2:0] rt_alu;

    always_comb begin
        funct_legal = 1'b1;
        rt_alu      = 3'b010;
        case (funct)
            6'b100000: rt_alu = 3'b010;
            6'b100010: rt_alu = 3'b110;
            6'b100100: rt_alu = 3'b000;
            6'b100101: rt_alu = 3'b001;
            6'b101010: rt_alu = 3'b111;
            6'b011000: rt_alu = 3'b101;
            default:   funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        op_legal   = 1'b1;
        state_next = state;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (op)
                    6'b100011, 6'b101011: state_next = MEMADR;
                    6'b000100:            state_next = BEQEX;
                    6'b001000:            state_next = ADDIEX;
                    6'b000010:            state_next = JEX;
`ifdef MC_BNE_EN
                    6'b000101:            state_next = BNEEX;
`endif
                    6'b000000:            if (funct_legal) state_next = RTEX;
                                          else op_legal = 1'b0;
                    default:              op_legal = 1'b0;
                endcase
                if (!op_legal) state_next = ILLEGAL_TRAP ? HALT : FETCH;
            end
            MEMADR: state_next = (op == 6'b101011) ? MEMWR : MEMRD;
            MEMRD:  state_next = MEMWB;
            RTEX:   state_next = RTWB;
            ADDIEX: state_next = ADDIWB;
            HALT:   state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // Output bundle for the state being entered; registered so outputs follow state exactly.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [2:0] rt_code);
        ctrl_t c;
        c = '0;
        c.alucontrol = 3'b010;
        case (s)
            FETCH:  begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
            DECODE: c.alusrcb = 2'b11;
            MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            MEMRD:  c.iord = 1'b1;
            MEMWB:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            MEMWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
            RTEX:   begin c.alusrca = 1'b1; c.alucontrol = rt_code; end
            RTWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            BEQEX, BNEEX: begin
                c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01;
                c.branch = 1'b1;  c.bne = (s == BNEEX);
            end
            ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            ADDIWB: c.regwrite = 1'b1;
            JEX:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            ctrl  <= ctrl_for(FETCH, 3'b010);
        end else begin
            state <= state_next;
            ctrl  <= ctrl_for(state_next, rt_alu);
        end
    end

    // Write-side enables are masked while reset is high so an abandoned instruction never commits.
    assign alucontrol = ctrl.alucontrol;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign pcsrc      = ctrl.pcsrc;
    assign iord       = ctrl.iord;
    assign regdst     = ctrl.regdst;
    assign memtoreg   = ctrl.memtoreg;
    assign irwrite    = ctrl.irwrite  & ~reset;
    assign memwrite   = ctrl.memwrite & ~reset;
    assign regwrite   = ctrl.regwrite & ~reset;
    assign pcen       = (ctrl.pcwrite | (ctrl.branch & (zero ^ ctrl.bne))) & ~reset;
    assign illegal    = (state == DECODE) & ~op_legal & ~reset;
    assign state_o    = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: one non-trapping and one trapping instance side by side.
module tb_mips_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;

    logic [2:0] alucontrol, alucontrol_t;
    logic       alusrca, alusrca_t;
    logic [1:0] alusrcb, alusrcb_t, pcsrc, pcsrc_t;
    logic       iord, iord_t, irwrite, irwrite_t, memwrite, memwrite_t;
    logic       regwrite, regwrite_t, regdst, regdst_t, memtoreg, memtoreg_t;
    logic       pcen, pcen_t, illegal, illegal_t;
    logic [3:0] state_o, state_o_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_mc_controller #(.ILLEGAL_TRAP(1'b0)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .pcen(pcen), .illegal(illegal),
        .state_o(state_o)
    );

    mips_mc_controller #(.ILLEGAL_TRAP(1'b1)) dut_t (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .alucontrol(alucontrol_t), .alusrca(alusrca_t), .alusrcb(alusrcb_t), .pcsrc(pcsrc_t),
        .iord(iord_t), .irwrite(irwrite_t), .memwrite(memwrite_t), .regwrite(regwrite_t),
        .regdst(regdst_t), .memtoreg(memtoreg_t), .pcen(pcen_t), .illegal(illegal_t),
        .state_o(state_o_t)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
        step(); step();
        chk("rst_state", state_o, 0);
        chk("rst_irwrite", irwrite, 0);
        chk("rst_pcen", pcen, 0);
        chk("rst_alusrcb", alusrcb, 2'b01);
        chk("rst_alucontrol", alucontrol, 3'b010);

        // lw: 0,1,2,3,4,0
        reset = 1'b0; op = 6'b100011; #1;
        chk("lw_fetch_irwrite", irwrite, 1);
        chk("lw_fetch_pcen", pcen, 1);
        step(); chk("lw_s1", state_o, 1); chk("lw_dec_alusrcb", alusrcb, 2'b11);
        chk("lw_dec_regwrite", regwrite, 0);
        step(); chk("lw_s2", state_o, 2); chk("lw_memadr_srcs", {alusrca, alusrcb}, 3'b110);
        step(); chk("lw_s3", state_o, 3); chk("lw_memrd_iord", iord, 1);
        chk("lw_memrd_regwrite", regwrite, 0);
        step(); chk("lw_s4", state_o, 4); chk("lw_memwb_wr", {regwrite, memtoreg, regdst}, 3'b110);
        step(); chk("lw_s0", state_o, 0); chk("lw_back_regwrite", regwrite, 0);

        // R-type slt then mul
        op = 6'b000000; funct = 6'b101010;
        step(); step(); chk("slt_s6", state_o, 6); chk("slt_alu", alucontrol, 3'b111);
        chk("slt_srcs", {alusrca, alusrcb}, 3'b100);
        step(); chk("slt_s7", state_o, 7); chk("slt_wb", {regdst, regwrite, memtoreg}, 3'b110);
        step(); chk("slt_s0", state_o, 0);
        funct = 6'b011000;
        step(); step(); chk("mul_alu", alucontrol, 3'b101);
        step(); step(); chk("mul_s0", state_o, 0);

        // beq taken then not taken
        op = 6'b000100; zero = 1'b1;
        step(); step(); chk("beq_s8", state_o, 8);
        chk("beq_t_pcen", pcen, 1); chk("beq_pcsrc", pcsrc, 2'b01); chk("beq_alu", alucontrol, 3'b110);
        step(); chk("beq_t_s0", state_o, 0);
        zero = 1'b0;
        step(); step(); chk("beq_nt_s8", state_o, 8); chk("beq_nt_pcen", pcen, 0);
        step(); chk("beq_nt_s0", state_o, 0);
        zero = 1'b1; step(); chk("dec_ignores_zero_pcen", pcen, 0);
        zero = 1'b0; step(); step(); chk("beq3_s0", state_o, 0);

        // illegal op: trap vs no trap
        op = 6'b111111;
        step(); chk("ill_s1", state_o, 1); chk("ill_pulse", illegal, 1); chk("ill_pulse_t", illegal_t, 1);
        step(); chk("ill_back_fetch", state_o, 0); chk("ill_pulse_end", illegal, 0);
        chk("ill_halt", state_o_t, 15);
        chk("halt_enables", {irwrite_t, pcen_t, memwrite_t, regwrite_t, illegal_t}, 5'b0);
        op = 6'b100011; step(); step();
        chk("halt_stays", state_o_t, 15); chk("halt_pcen", pcen_t, 0);
        reset = 1'b1; step(); reset = 1'b0; #1;
        chk("halt_reset", state_o_t, 0); chk("norm_reset", state_o, 0);

        // sw with reset in MEMWR
        op = 6'b101011;
        step(); step(); step(); chk("sw_s5", state_o, 5); chk("sw_memwrite", memwrite, 1);
        chk("sw_iord", iord, 1);
        reset = 1'b1; #1; chk("sw_rst_memwrite", memwrite, 0);
        step(); chk("sw_rst_s0", state_o, 0);
        reset = 1'b0; op = 6'b001000; #1; chk("refetch_irwrite", irwrite, 1);

        // addi
        step(); step(); chk("addi_s9", state_o, 9); chk("addi_srcs", {alusrca, alusrcb}, 3'b110);
        step(); chk("addi_s10", state_o, 10); chk("addi_wb", {regwrite, regdst, memtoreg}, 3'b100);
        step(); chk("addi_s0", state_o, 0);

        // j
        op = 6'b000010;
        step(); step(); chk("j_s11", state_o, 11); chk("j_pcen", pcen, 1); chk("j_pcsrc", pcsrc, 2'b10);
        step(); chk("j_s0", state_o, 0);

        // illegal funct with op 0 must not enter RTEX
        op = 6'b000000; funct = 6'b000000;
        step(); chk("badfunct_pulse", illegal, 1);
        step(); chk("badfunct_s0", state_o, 0);
        reset = 1'b1; step(); reset = 1'b0;

        // bne
        op = 6'b000101; zero = 1'b0;
        step();
`ifdef MC_BNE_EN
        chk("bne_no_illegal", illegal, 0);
        step(); chk("bne_s12", state_o, 12); chk("bne_pcen", pcen, 1);
        zero = 1'b1; #1; chk("bne_nt_pcen", pcen, 0);
        step(); chk("bne_s0", state_o, 0);
`else
        chk("bne_illegal", illegal, 1);
        step(); chk("bne_off_s0", state_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
